// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parametrised serial pattern detector. Consumes one bit per
//                cycle while en=1 and compares the last LEN consumed bits
//                against PATTERN (MSB = oldest bit). Provides a combinational
//                Mealy strobe, a registered one-cycle strobe and a saturating
//                match counter. Overlapping matches are selectable.
//  Parameters  : LEN     - pattern length, 2..32
//                PATTERN - LEN-bit pattern, MSB arrives first
//                OVERLAP - 1: matches may share bits, 0: LEN fresh bits needed
//                CNT_W   - match counter width, 1..32
//  Ports       : clk     - clock, rising edge
//                rst     - asynchronous active-high reset
//                en      - bit valid; din consumed only when en=1
//                din     - serial data bit
//                clr     - synchronous clear of history, fill and count
//                match   - combinational strobe on the final pattern bit
//                match_r - match delayed by one clock
//                count   - saturating number of matches
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int unsigned      LEN     = 5,
    parameter logic [LEN-1:0]   PATTERN = 5'b10010,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             match,
    output logic             match_r,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned            c_FILL_W   = (LEN > 2) ? $clog2(LEN) : 1;
    localparam logic [c_FILL_W-1:0]    c_FILL_MAX = c_FILL_W'(LEN - 1);

    logic [LEN-2:0]      r_hist_q;
    logic [LEN-2:0]      w_hist_d;
    logic [c_FILL_W-1:0] r_fill_q;
    logic [c_FILL_W-1:0] w_fill_d;
    logic [CNT_W-1:0]    r_count_q;
    logic [CNT_W-1:0]    w_count_d;
    logic                r_match_r_q;
    logic                w_match_r_d;

    // Candidate LEN-bit window: stored history plus the bit on the wire now.
    logic [LEN-1:0]      w_window;
    logic                w_match;

    assign w_window = {r_hist_q, din};

    // fill gates detection so partial history after reset/clear/non-overlap
    // match can never produce a false hit.
    assign w_match = en & ~clr & (r_fill_q == c_FILL_MAX) & (w_window == PATTERN);

    always_comb begin
        w_hist_d    = r_hist_q;
        w_fill_d    = r_fill_q;
        w_count_d   = r_count_q;
        w_match_r_d = w_match;

        if (clr) begin
            w_hist_d    = '0;
            w_fill_d    = '0;
            w_count_d   = '0;
            w_match_r_d = 1'b0;
        end else if (en) begin
            // Dropping the window MSB keeps the newest LEN-1 bits; this also
            // covers LEN=2 where the history is a single bit.
            w_hist_d = w_window[LEN-2:0];

            if (w_match && !OVERLAP) begin
                w_fill_d = '0;
            end else if (r_fill_q != c_FILL_MAX) begin
                w_fill_d = r_fill_q + c_FILL_W'(1);
            end

            if (w_match && !(&r_count_q)) begin
                w_count_d = r_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hist_q    <= '0;
            r_fill_q    <= '0;
            r_count_q   <= '0;
            r_match_r_q <= 1'b0;
        end else begin
            r_hist_q    <= w_hist_d;
            r_fill_q    <= w_fill_d;
            r_count_q   <= w_count_d;
            r_match_r_q <= w_match_r_d;
        end
    end

    assign match   = w_match;
    assign match_r = r_match_r_q;
    assign count   = r_count_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Self-checking bench for seq_detect_param. Three instances
//                (overlap default, non-overlap default, LEN=2 CNT_W=2 "11")
//                share one stimulus stream and are compared every cycle
//                against a bit-history reference model, plus directed
//                literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;
    logic din = 1'b0;
    logic clr = 1'b0;

    logic [2:0] dut_m;
    logic [2:0] dut_mr;
    logic [7:0] cnt0;
    logic [7:0] cnt1;
    logic [1:0] cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_param #(.LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b1), .CNT_W(8)) u_ov (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .match(dut_m[0]), .match_r(dut_mr[0]), .count(cnt0));

    seq_detect_param #(.LEN(5), .PATTERN(5'b10010), .OVERLAP(1'b0), .CNT_W(8)) u_nov (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .match(dut_m[1]), .match_r(dut_mr[1]), .count(cnt1));

    seq_detect_param #(.LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .match(dut_m[2]), .match_r(dut_mr[2]), .count(cnt2));

    // Reference configuration per instance
    localparam int P_LEN [3] = '{5, 5, 2};
    localparam int P_PAT [3] = '{18, 18, 3};
    localparam int P_OV  [3] = '{1, 0, 1};
    localparam int P_CMAX[3] = '{255, 255, 3};

    // Reference model: bits consumed since the last restart, their recent
    // values, match count and the delayed strobe.
    int          m_nb  [3];
    logic [31:0] m_rec [3];
    int          m_cnt [3];
    int          m_mr  [3];

    function automatic int dut_cnt(input int i);
        if (i == 0) return int'(cnt0);
        if (i == 1) return int'(cnt1);
        return int'(cnt2);
    endfunction

    function automatic int model_match(input int i);
        logic [31:0] mask;
        logic [31:0] w;
        if (rst || !en || clr) return 0;
        if (m_nb[i] < P_LEN[i] - 1) return 0;
        mask = (32'd1 << P_LEN[i]) - 32'd1;
        w = ((m_rec[i] << 1) | {31'd0, din}) & mask;
        return (w == P_PAT[i]) ? 1 : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            m_nb[i] = 0; m_rec[i] = '0; m_cnt[i] = 0; m_mr[i] = 0;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model across the
    // coming rising edge (inputs are stable from here to that edge).
    initial begin
        int em [3];
        model_clear();
        forever begin
            @(negedge clk);
            if (rst) model_clear();
            for (int i = 0; i < 3; i++) begin
                em[i] = model_match(i);
                check($sformatf("match[%0d]", i), int'(dut_m[i]), em[i]);
                check($sformatf("match_r[%0d]", i), int'(dut_mr[i]), m_mr[i]);
                check($sformatf("count[%0d]", i), dut_cnt(i), m_cnt[i]);
            end
            if (!rst) begin
                for (int i = 0; i < 3; i++) begin
                    if (clr) begin
                        m_nb[i] = 0; m_rec[i] = '0; m_cnt[i] = 0; m_mr[i] = 0;
                    end else if (en) begin
                        m_rec[i] = (m_rec[i] << 1) | {31'd0, din};
                        if (em[i] == 1 && P_OV[i] == 0) m_nb[i] = 0;
                        else if (m_nb[i] < 1000) m_nb[i] = m_nb[i] + 1;
                        if (em[i] == 1 && m_cnt[i] < P_CMAX[i]) m_cnt[i] = m_cnt[i] + 1;
                        m_mr[i] = em[i];
                    end else begin
                        m_mr[i] = 0;
                    end
                end
            end
        end
    end

    // Drive one cycle of inputs shortly after the rising edge, return just
    // after the falling edge so outputs can be sampled.
    task automatic drive(input bit r, input bit e, input bit d, input bit c);
        @(posedge clk);
        #2;
        rst = r; en = e; din = d; clr = c;
        @(negedge clk);
        #1;
    endtask

    task automatic consume(input bit d);
        drive(1'b0, 1'b1, d, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit seq8  [8]  = '{1, 0, 0, 1, 0, 0, 1, 0};
        bit seq5  [5]  = '{1, 0, 0, 1, 0};
        bit prev0;

        // Reset held for two cycles with traffic on the inputs
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
            check("rst_match", int'(dut_m), 0);
            check("rst_match_r", int'(dut_mr), 0);
            check("rst_count0", int'(cnt0), 0);
        end
        idle();
        check("post_rst_count0", int'(cnt0), 0);

        // Overlap vs non-overlap on 10010010
        prev0 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            consume(seq8[k-1]);
            check($sformatf("ov_bit%0d", k), int'(dut_m[0]), (k == 5 || k == 8) ? 1 : 0);
            check($sformatf("nov_bit%0d", k), int'(dut_m[1]), (k == 5) ? 1 : 0);
            check($sformatf("ov_mr_bit%0d", k), int'(dut_mr[0]), int'(prev0));
            prev0 = dut_m[0];
        end
        idle();
        check("ov_mr_last", int'(dut_mr[0]), 1);
        check("ov_count", int'(cnt0), 2);
        check("nov_count8", int'(cnt1), 1);

        // Bits 9,10 complete only 01010 for the non-overlap window
        consume(1'b1);
        consume(1'b0);
        check("nov_bit10", int'(dut_m[1]), 0);
        for (int k = 0; k < 5; k++) begin
            consume(seq5[k]);
            check($sformatf("nov_fresh%0d", k), int'(dut_m[1]), (k == 4) ? 1 : 0);
        end
        idle();
        check("nov_count", int'(cnt1), 2);

        // en gating: 1,0,0 / gap / 1,0
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        consume(1'b1); consume(1'b0); consume(1'b0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b0, 1'(k[0]), 1'b0);
            check("gap_match", int'(dut_m), 0);
        end
        consume(1'b1);
        check("gap_bit4", int'(dut_m[0]), 0);
        consume(1'b0);
        check("gap_bit5", int'(dut_m[0]), 1);
        idle();
        check("gap_count", int'(cnt0), 1);

        // Asynchronous reset mid-operation
        consume(1'b1); consume(1'b0); consume(1'b0); consume(1'b1);
        check("pre_rst_count0", int'(cnt0), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        check("async_rst_count0", int'(cnt0), 0);
        check("async_rst_count1", int'(cnt1), 0);
        consume(1'b0);
        check("after_rst_bit", int'(dut_m[0]), 0);
        for (int k = 0; k < 5; k++) begin
            consume(seq5[k]);
            check($sformatf("fresh%0d", k), int'(dut_m[0]), (k == 4) ? 1 : 0);
        end

        // Saturation on LEN=2 pattern 11 with CNT_W=2
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        for (int k = 1; k <= 7; k++) begin
            consume(1'b1);
            check($sformatf("sat_match%0d", k), int'(dut_m[2]), (k >= 2) ? 1 : 0);
            check($sformatf("sat_count%0d", k), int'(cnt2), (k >= 3) ? ((k - 2 > 3) ? 3 : k - 2) : 0);
        end
        drive(1'b0, 1'b1, 1'b1, 1'b1);
        check("sat_clr_match", int'(dut_m[2]), 0);
        check("sat_clr_count_before", int'(cnt2), 3);
        idle();
        check("sat_clr_count", int'(cnt2), 0);
        check("sat_clr_match_r", int'(dut_mr[2]), 0);

        // Randomised traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 499) == 0) begin
                drive(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            end else begin
                drive(1'b0,
                      ($urandom_range(0, 3) != 0),
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 63) == 0));
            end
        end
        idle();
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
